// File: rtl/rot_transform_seq.sv
// rtl/rot_transform_seq.sv - sequential 2-D rotation by k*45 deg using one shared shift-add multiplier
module rot_transform_seq #(
    parameter int W    = 16,
    parameter int FRAC = 13
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [2:0]          angle,
    input  logic signed [W-1:0] x_in,
    input  logic signed [W-1:0] y_in,
    input  logic signed [W-1:0] z_in,
    output logic signed [W-1:0] x_out,
    output logic signed [W-1:0] y_out,
    output logic signed [W-1:0] z_out,
    output logic                busy,
    output logic                done,
    output logic                sat
);

    // product width (exact W x 16 signed) and sum width (one guard bit)
    localparam int PW = W + 16;
    localparam int SW = W + 17;
    localparam logic signed [SW-1:0] MAX_V    = SW'((64'sd1 <<< (W - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] MIN_V    = ~MAX_V;
    localparam logic signed [SW-1:0] RND_HALF = SW'(64'sd1 <<< (FRAC - 1));

    typedef enum logic [1:0] {IDLE, MUL, SUM} state_t;

    state_t state_q, state_d;

    logic signed [W-1:0]  x_q, y_q, z_q;
    logic [2:0]           ang_q;
    logic                 mode_q;
    logic [1:0]           idx_q;
    logic [3:0]           bit_q;
    logic signed [PW-1:0] acc_q;
    logic signed [PW-1:0] p_xc, p_ys, p_xs, p_yc;

    logic signed [15:0]   coef_c, coef_s, mul_b;
    logic signed [W-1:0]  mul_a;
    logic signed [PW-1:0] a_ext, partial, acc_base, acc_sum;
    logic signed [SW-1:0] sum_x, sum_y, rnd_x, rnd_y;
    logic signed [W-1:0]  res_x, res_y;
    logic                 clip_x, clip_y;

    function automatic logic signed [15:0] lut_cos(input logic [2:0] k);
        case (k)
            3'd0:    lut_cos = 16'sd8192;
            3'd1:    lut_cos = 16'sd5793;
            3'd2:    lut_cos = 16'sd0;
            3'd3:    lut_cos = -16'sd5793;
            3'd4:    lut_cos = -16'sd8192;
            3'd5:    lut_cos = -16'sd5793;
            3'd6:    lut_cos = 16'sd0;
            default: lut_cos = 16'sd5793;
        endcase
    endfunction

    function automatic logic signed [15:0] lut_sin(input logic [2:0] k);
        case (k)
            3'd0:    lut_sin = 16'sd0;
            3'd1:    lut_sin = 16'sd5793;
            3'd2:    lut_sin = 16'sd8192;
            3'd3:    lut_sin = 16'sd5793;
            3'd4:    lut_sin = 16'sd0;
            3'd5:    lut_sin = -16'sd5793;
            3'd6:    lut_sin = -16'sd8192;
            default: lut_sin = -16'sd5793;
        endcase
    endfunction

    // operand selection and one shift-add step; bit 15 of the coefficient carries negative weight
    always_comb begin
        coef_c   = lut_cos(ang_q);
        coef_s   = mode_q ? -lut_sin(ang_q) : lut_sin(ang_q);
        mul_a    = idx_q[0] ? y_q : x_q;
        mul_b    = (idx_q == 2'd0 || idx_q == 2'd3) ? coef_c : coef_s;
        a_ext    = {{16{mul_a[W-1]}}, mul_a};
        partial  = mul_b[bit_q] ? (a_ext <<< bit_q) : '0;
        acc_base = (bit_q == 4'd0) ? '0 : acc_q;
        acc_sum  = (bit_q == 4'd15) ? (acc_base - partial) : (acc_base + partial);
    end

    // final combine, round half up and clip to the output range
    always_comb begin
        sum_x  = {p_xc[PW-1], p_xc} - {p_ys[PW-1], p_ys};
        sum_y  = {p_xs[PW-1], p_xs} + {p_yc[PW-1], p_yc};
        rnd_x  = (sum_x + RND_HALF) >>> FRAC;
        rnd_y  = (sum_y + RND_HALF) >>> FRAC;
        clip_x = (rnd_x > MAX_V) || (rnd_x < MIN_V);
        clip_y = (rnd_y > MAX_V) || (rnd_y < MIN_V);
        res_x  = (rnd_x > MAX_V) ? MAX_V[W-1:0] : (rnd_x < MIN_V) ? MIN_V[W-1:0] : rnd_x[W-1:0];
        res_y  = (rnd_y > MAX_V) ? MAX_V[W-1:0] : (rnd_y < MIN_V) ? MIN_V[W-1:0] : rnd_y[W-1:0];
    end

    // next-state logic: four 16-step products, then one combine cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = MUL;
            MUL:     if (bit_q == 4'd15 && idx_q == 2'd3) state_d = SUM;
            SUM:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // operand capture, multiplier iteration and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            ang_q  <= '0;
            mode_q <= 1'b0;
            idx_q  <= '0;
            bit_q  <= '0;
            acc_q  <= '0;
            p_xc   <= '0;
            p_ys   <= '0;
            p_xs   <= '0;
            p_yc   <= '0;
            x_out  <= '0;
            y_out  <= '0;
            z_out  <= '0;
            sat    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_q    <= x_in;
                        y_q    <= y_in;
                        z_q    <= z_in;
                        ang_q  <= angle;
                        mode_q <= mode;
                        idx_q  <= '0;
                        bit_q  <= '0;
                        busy   <= 1'b1;
                    end
                end
                MUL: begin
                    acc_q <= acc_sum;
                    bit_q <= bit_q + 4'd1;
                    if (bit_q == 4'd15) begin
                        case (idx_q)
                            2'd0:    p_xc <= acc_sum;
                            2'd1:    p_ys <= acc_sum;
                            2'd2:    p_xs <= acc_sum;
                            default: p_yc <= acc_sum;
                        endcase
                        idx_q <= idx_q + 2'd1;
                    end
                end
                SUM: begin
                    x_out <= res_x;
                    y_out <= res_y;
                    z_out <= z_q;
                    sat   <= clip_x | clip_y;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rot_transform_seq.sv
// tb/tb_rot_transform_seq.sv - directed self-checking bench for rot_transform_seq
module tb_rot_transform_seq;

    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst, start, mode;
    logic [2:0]          angle;
    logic signed [W-1:0] x_in, y_in, z_in;
    logic signed [W-1:0] x_out, y_out, z_out;
    logic                busy, done, sat;

    int total = 0;
    int bad   = 0;

    rot_transform_seq #(.W(W), .FRAC(13)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .angle(angle),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .x_out(x_out), .y_out(y_out), .z_out(z_out),
        .busy(busy), .done(done), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int xi, input int yi, input int zi, input int ang, input int md);
        x_in  = W'(xi);
        y_in  = W'(yi);
        z_in  = W'(zi);
        angle = 3'(ang);
        mode  = md[0];
    endtask

    // one operation: start sampled on the next edge, latency and busy span measured
    task automatic run_op(input string tag, input int xi, input int yi, input int zi,
                          input int ang, input int md,
                          input int ex, input int ey, input int ez, input int es);
        int lat;
        int busy_cnt;
        set_in(xi, yi, zi, ang, md);
        start = 1'b1;
        step();
        start = 1'b0;
        set_in(123, -321, 55, 7, 1 - md);
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 200) begin
            step();
            lat++;
            if (busy) busy_cnt++;
        end
        chk({tag, "_lat"}, lat, 65);
        chk({tag, "_busy"}, busy_cnt, 65);
        chk({tag, "_x"}, int'(x_out), ex);
        chk({tag, "_y"}, int'(y_out), ey);
        chk({tag, "_z"}, int'(z_out), ez);
        chk({tag, "_sat"}, int'(sat), es);
    endtask

    initial begin
        int n;
        int dones;
        int first_done;

        rst = 1'b1;
        start = 1'b0;
        set_in(0, 0, 0, 0, 0);
        step();
        step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_x", int'(x_out), 0);
        chk("rst_y", int'(y_out), 0);
        chk("rst_z", int'(z_out), 0);
        chk("rst_sat", int'(sat), 0);

        // first start coincides with the first edge that has rst low
        rst = 1'b0;
        run_op("ang0", 1000, -2000, 77, 0, 0, 1000, -2000, 77, 0);
        step();
        chk("done_pulse", int'(done), 0);

        run_op("ang2_m0", 1000, 500, 3, 2, 0, -500, 1000, 3, 0);
        run_op("ang2_m1", 1000, 500, -4, 2, 1, 500, -1000, -4, 0);
        run_op("ang1_m0", 8192, 8192, 9, 1, 0, 0, 11586, 9, 0);
        run_op("ang1_m1", 8192, 8192, 10, 1, 1, 11586, 0, 10, 0);
        run_op("sat_pos", 32767, 32767, 1, 1, 0, 0, 32767, 1, 1);
        run_op("sat_neg", -32768, 0, 2, 4, 0, 32767, 0, 2, 1);
        step();
        chk("done_pulse2", int'(done), 0);

        // extra start pulses and input churn while busy must be ignored
        set_in(1000, 500, 11, 2, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        set_in(-7, 9, 99, 5, 1);
        dones = 0;
        first_done = -1;
        for (n = 1; n <= 140; n++) begin
            start = (n == 10 || n == 64) ? 1'b1 : 1'b0;
            step();
            if (done) begin
                dones++;
                if (first_done < 0) first_done = n;
            end
        end
        start = 1'b0;
        chk("ign_dones", dones, 1);
        chk("ign_lat", first_done, 65);
        chk("ign_x", int'(x_out), -500);
        chk("ign_y", int'(y_out), 1000);
        chk("ign_z", int'(z_out), 11);

        // back-to-back: second start issued on the done cycle
        run_op("b2b_a", 1000, 500, 5, 2, 1, 500, -1000, 5, 0);
        run_op("b2b_b", 8192, 8192, 6, 1, 0, 0, 11586, 6, 0);

        // reset 30 cycles into an operation aborts it without a completion
        set_in(1000, -2000, 77, 0, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (29) step();
        chk("abort_busy_pre", int'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_x", int'(x_out), 0);
        chk("abort_y", int'(y_out), 0);
        chk("abort_z", int'(z_out), 0);
        chk("abort_sat", int'(sat), 0);
        dones = 0;
        for (n = 0; n < 100; n++) begin
            step();
            if (done) dones++;
        end
        chk("abort_nodone", dones, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
